nios2_qsys_mul_sequencer: RTL and testbench

- Issue/retire stage wrapped around the 2-stage hard multiplier cell of the Nios II core. Register boundaries are E -> M on M_en, and M -> A on A_en.
- Upstream, it accepts multiply requests on a valid/ready handshake. It decodes the opcode into per-operand sign controls, drives the cell's E-stage operands, and generates the cell's M_en/A_en so the cell pipeline freezes under back-pressure.
- It tracks in-flight ops and their tags alongside the cell latency.
- On retire, it selects the low or high 32-bit word of the 64-bit product and presents it on a valid/ready result interface.

---
 rtl/nios2_mul_pkg.sv | 16 +
 rtl/nios2_mul_stage_reg.sv | 44 ++++
 rtl/nios2_qsys_mul_sequencer.sv | 88 ++++++++
 tb/tb_nios2_qsys_mul_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: opcode encoding, cell latency and sign decode for the multiply sequencer
package nios2_mul_pkg;

    localparam logic [1:0] MUL_OP_MUL = 2'd0;
    localparam logic [1:0] MUL_OP_XSS = 2'd1;
    localparam logic [1:0] MUL_OP_XSU = 2'd2;
    localparam logic [1:0] MUL_OP_XUU = 2'd3;

    localparam int MUL_LAT = 2;

    // returns {signa, signb}; only the mixed/signed high-word forms treat operands as signed
    function automatic logic [1:0] mul_op_signs(input logic [1:0] op);
        return {op == MUL_OP_XSS || op == MUL_OP_XSU, op == MUL_OP_XSS};
    endfunction

endpackage

// File: rtl/nios2_mul_stage_reg.sv
// nios2_mul_stage_reg: valid/op/tag pipeline register with enable and flush
module nios2_mul_stage_reg #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_flush,
    input  logic             i_vld,
    input  logic [1:0]       i_op,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [1:0]       o_op,
    output logic [TAG_W-1:0] o_tag
);
    import nios2_mul_pkg::*;

    logic             r_vld;
    logic [1:0]       r_op;
    logic [TAG_W-1:0] r_tag;

    // flush kills the valid even while stalled; op/tag just follow the enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= 1'b0;
            r_op  <= MUL_OP_MUL;
            r_tag <= '0;
        end else begin
            if (i_flush)
                r_vld <= 1'b0;
            else if (i_en)
                r_vld <= i_vld;
            if (i_en) begin
                r_op  <= i_op;
                r_tag <= i_tag;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_op  = r_op;
    assign o_tag = r_tag;

endmodule

// File: rtl/nios2_qsys_mul_sequencer.sv
// nios2_qsys_mul_sequencer: issue/retire control around the 2-stage hard multiplier cell
module nios2_qsys_mul_sequencer #(
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = nios2_mul_pkg::MUL_LAT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [31:0]      E_src1_mul_cell,
    output logic [31:0]      E_src2_mul_cell,
    output logic             E_ctrl_mul_shift_src1_signed,
    output logic             E_ctrl_mul_shift_src2_signed,
    output logic             M_en,
    output logic             A_en,
    input  logic [63:0]      A_mul_cell_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    import nios2_mul_pkg::*;

    if (MUL_LAT != 2) begin : g_lat_check
        $error("nios2_qsys_mul_sequencer: the multiplier cell latency is fixed at 2");
    end

    logic             w_advance;
    logic             w_m_vld;
    logic             w_a_vld;
    logic [1:0]       w_m_op;
    logic [1:0]       w_a_op;
    logic [1:0]       w_signs;
    logic [TAG_W-1:0] w_m_tag;
    logic [TAG_W-1:0] w_a_tag;

    // the whole pipe, cell included, moves only when the A slot is empty or draining
    assign w_advance = ~w_a_vld | out_ready;
    assign M_en      = w_advance;
    assign A_en      = w_advance;
    assign in_ready  = w_advance & ~flush;

    // operands go straight to the cell; it only samples them on an M_en edge
    assign w_signs                      = mul_op_signs(in_op);
    assign E_src1_mul_cell              = in_src1;
    assign E_src2_mul_cell              = in_src2;
    assign E_ctrl_mul_shift_src1_signed = w_signs[1];
    assign E_ctrl_mul_shift_src2_signed = w_signs[0];

    nios2_mul_stage_reg #(.TAG_W(TAG_W)) u_m_stage (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_advance),
        .i_flush (flush),
        .i_vld   (in_valid & in_ready),
        .i_op    (in_op),
        .i_tag   (in_tag),
        .o_vld   (w_m_vld),
        .o_op    (w_m_op),
        .o_tag   (w_m_tag)
    );

    nios2_mul_stage_reg #(.TAG_W(TAG_W)) u_a_stage (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_advance),
        .i_flush (flush),
        .i_vld   (w_m_vld),
        .i_op    (w_m_op),
        .i_tag   (w_m_tag),
        .o_vld   (w_a_vld),
        .o_op    (w_a_op),
        .o_tag   (w_a_tag)
    );

    // a squash cycle must not complete a result handshake
    assign out_valid  = w_a_vld & ~flush;
    assign out_tag    = w_a_tag;
    assign out_result = (w_a_op == MUL_OP_MUL) ? A_mul_cell_result[31:0] : A_mul_cell_result[63:32];
    assign busy       = w_m_vld | w_a_vld;

endmodule

// File: tb/tb_nios2_qsys_mul_sequencer.sv
// tb_nios2_qsys_mul_sequencer: randomized + directed bench against a queue-based model
module tb_nios2_qsys_mul_sequencer;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic [31:0]      E_src1_mul_cell;
    logic [31:0]      E_src2_mul_cell;
    logic             E_ctrl_mul_shift_src1_signed;
    logic             E_ctrl_mul_shift_src2_signed;
    logic             M_en;
    logic             A_en;
    logic [63:0]      A_mul_cell_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    always #5 clk = ~clk;

    nios2_qsys_mul_sequencer #(.TAG_W(TAG_W)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .in_valid                     (in_valid),
        .in_ready                     (in_ready),
        .in_op                        (in_op),
        .in_src1                      (in_src1),
        .in_src2                      (in_src2),
        .in_tag                       (in_tag),
        .flush                        (flush),
        .E_src1_mul_cell              (E_src1_mul_cell),
        .E_src2_mul_cell              (E_src2_mul_cell),
        .E_ctrl_mul_shift_src1_signed (E_ctrl_mul_shift_src1_signed),
        .E_ctrl_mul_shift_src2_signed (E_ctrl_mul_shift_src2_signed),
        .M_en                         (M_en),
        .A_en                         (A_en),
        .A_mul_cell_result            (A_mul_cell_result),
        .out_valid                    (out_valid),
        .out_ready                    (out_ready),
        .out_result                   (out_result),
        .out_tag                      (out_tag),
        .busy                         (busy)
    );

    // 64-bit product of two 32-bit operands, each optionally treated as signed
    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
        logic [63:0] x;
        logic [63:0] y;
        x = sa ? {{32{a[31]}}, a} : {32'b0, a};
        y = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return x * y;
    endfunction

    function automatic logic [31:0] expect_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = prod(a, b, op == 2'd1 || op == 2'd2, op == 2'd1);
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // stand-in for the hard multiplier cell: operand register on M_en, product register on A_en
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic        c_sa;
    logic        c_sb;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            c_a <= '0;
            c_b <= '0;
            c_sa <= 1'b0;
            c_sb <= 1'b0;
            A_mul_cell_result <= '0;
        end else begin
            if (M_en) begin
                c_a <= E_src1_mul_cell;
                c_b <= E_src2_mul_cell;
                c_sa <= E_ctrl_mul_shift_src1_signed;
                c_sb <= E_ctrl_mul_shift_src2_signed;
            end
            if (A_en)
                A_mul_cell_result <= prod(c_a, c_b, c_sa, c_sb);
        end
    end

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               age;
    } ent_t;

    ent_t             q[$];
    logic [TAG_W-1:0] seen_tags[$];
    int               checks = 0;
    int               errors = 0;
    int               obs_ret = 0;
    int               stall_seen = 0;
    logic             last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_has();
        return q.size() > 0 && q[0].age == 2;
    endfunction

    // compare every DUT output against the model, mid-cycle with inputs settled
    task automatic compare();
        logic has;
        logic adv;
        has = model_has();
        adv = !has || out_ready;
        if (reset) begin
            chk("rst_in_ready", in_ready, !flush);
            chk("rst_M_en", M_en, 1);
            chk("rst_A_en", A_en, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_tag", out_tag, 0);
            return;
        end
        chk("in_ready", in_ready, adv && !flush);
        chk("M_en", M_en, adv);
        chk("A_en", A_en, adv);
        chk("out_valid", out_valid, has && !flush);
        chk("busy", busy, q.size() > 0);
        chk("E_src1", E_src1_mul_cell, in_src1);
        chk("E_src2", E_src2_mul_cell, in_src2);
        chk("signa", E_ctrl_mul_shift_src1_signed, in_op == 2'd1 || in_op == 2'd2);
        chk("signb", E_ctrl_mul_shift_src2_signed, in_op == 2'd1);
        if (has && !flush) begin
            chk("out_result", out_result, q[0].res);
            chk("out_tag", out_tag, q[0].tag);
        end
        if (out_valid && out_ready) begin
            obs_ret++;
            seen_tags.push_back(out_tag);
        end
        if (out_valid && !out_ready && !M_en)
            stall_seen++;
    endtask

    // advance the model across one clock edge using the inputs that were presented
    task automatic model_edge();
        logic has;
        logic adv;
        has = model_has();
        adv = !has || out_ready;
        last_acc = 1'b0;
        if (reset || flush) begin
            q.delete();
            return;
        end
        if (adv) begin
            if (has)
                void'(q.pop_front());
            foreach (q[i])
                q[i].age = q[i].age + 1;
            if (in_valid) begin
                q.push_back('{expect_res(in_op, in_src1, in_src2), in_tag, 1});
                last_acc = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_op = op;
        in_src1 = a;
        in_src2 = b;
        in_tag = tag;
        out_ready = ordy;
        flush = fl;
        #2;
        compare();
        @(posedge clk);
        model_edge();
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] exp);
        step(1, op, a, b, tag, 1, 0);
        #1;
        chk({name, "_not_yet"}, out_valid, 0);
        chk({name, "_busy"}, busy, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_result"}, out_result, exp);
        chk({name, "_tag"}, out_tag, tag);
        step(0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int r0;
        int idx;
        int stall;
        bit stalled;
        reset = 1'b0;
        in_valid = 1'b0;
        in_op = 2'd0;
        in_src1 = '0;
        in_src2 = '0;
        in_tag = '0;
        flush = 1'b0;
        out_ready = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 compare();
        @(negedge clk);
        reset = 1'b0;

        run_one("mul7x6", 2'd0, 32'd7, 32'd6, 5'd9, 32'h0000002A);
        run_one("xss", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000);
        run_one("xuu", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE);
        run_one("xsu", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF);

        // stream of four ops with a three-cycle consumer stall on the first result
        seen_tags.delete();
        r0 = obs_ret;
        stall_seen = 0;
        idx = 0;
        stall = 0;
        stalled = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!stalled && model_has()) begin
                stalled = 1'b1;
                stall = 3;
            end
            step(idx < 4, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'(idx + 1), stall == 0, 0);
            if (stall > 0)
                stall--;
            if (last_acc)
                idx++;
        end
        chk("bp_retired", obs_ret - r0, 4);
        chk("bp_stall_cycles", stall_seen, 3);
        chk("bp_seen_count", seen_tags.size(), 4);
        for (int i = 0; i < 4 && i < seen_tags.size(); i++)
            chk("bp_order", seen_tags[i], i + 1);

        // flush with two ops in flight and a third request offered
        step(1, 2'd0, 32'd2, 32'd3, 5'd20, 1, 0);
        step(1, 2'd1, 32'd4, 32'd5, 5'd21, 1, 0);
        r0 = obs_ret;
        step(1, 2'd3, 32'd6, 32'd7, 5'd22, 1, 1);
        #1;
        chk("flush_busy", busy, 0);
        chk("flush_no_accept", last_acc, 0);
        repeat (4) step(0, 0, 0, 0, 0, 1, 0);
        chk("flush_no_results", obs_ret - r0, 0);

        // async reset between edges drops everything in flight
        step(1, 2'd0, 32'd11, 32'd12, 5'd10, 1, 0);
        step(1, 2'd0, 32'd13, 32'd14, 5'd11, 1, 0);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #1 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        q.delete();
        @(negedge clk);
        #1 compare();
        @(negedge clk);
        #3 reset = 1'b0;
        run_one("mul3x5", 2'd0, 32'd3, 32'd5, 5'd17, 32'h0000000F);

        // randomized traffic with random back-pressure and occasional flushes
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 5'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        repeat (5) step(0, 0, 0, 0, 0, 1, 0);
        chk("drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
